icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 25 ++
 rtl/icache_array.sv | 54 +++++
 rtl/icache.sv | 189 ++++++++++++++++++
 tb/tb_icache.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: address/word types and FSM state encoding.
package icache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef logic [ADDR_W-1:0] addr_tp;
    typedef logic [31:0]       word_tp;
    typedef logic [BYTE_W-1:0] byte_tp;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side buses of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic   req_valid;
    addr_tp req_addr;
    logic   req_ready;
    logic   resp_valid;
    word_tp resp_inst;
    logic   mem_rd_en;
    addr_tp mem_rd_addr;
    logic   mem_rd_valid;
    byte_tp mem_rd_data;

    modport slave (
        input  req_valid, req_addr, mem_rd_valid, mem_rd_data,
        output req_ready, resp_valid, resp_inst, mem_rd_en, mem_rd_addr
    );

    modport master (
        output req_valid, req_addr, mem_rd_valid, mem_rd_data,
        input  req_ready, resp_valid, resp_inst, mem_rd_en, mem_rd_addr
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: asynchronous read, synchronous write.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  word_tp           wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output word_tp           rd_data
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    word_tp           data_mem [DEPTH];

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and data memories are deliberately not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with byte-serial refill from the memory controller.
// Optional hit/miss counters are enabled by defining ICACHE_STAT_EN.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned CACHE_SZ = 256,
    parameter int unsigned LINE_SZ  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    icache_if.slave     bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned OFF_W = $clog2(LINE_SZ);
    localparam int unsigned IDX_W = $clog2(CACHE_SZ);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

    state_e                   state_q, state_d;
    logic [OFF_W-1:0]         beat_q, beat_d;
    logic [LINE_SZ-1:0][7:0]  line_q, line_d;
    logic                     resp_valid_q, resp_valid_d;
    word_tp                   resp_inst_q, resp_inst_d;
    logic                     mem_rd_en_q, mem_rd_en_d;
    addr_tp                   mem_rd_addr_q, mem_rd_addr_d;

    logic [IDX_W-1:0]         req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    word_tp                   rd_data;
    logic                     hit;
    logic                     accept;
    logic                     last_beat;
    logic                     install;
    logic [LINE_SZ-1:0][7:0]  fill_line;
    logic                     unused_addr_bits;

    assign req_idx          = bus.req_addr[OFF_W +: IDX_W];
    assign req_tag          = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^bus.req_addr[OFF_W-1:0];

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign accept    = rdy && !flush && bus.req_valid && (state_q == ST_IDLE);
    assign last_beat = (beat_q == OFF_W'(LINE_SZ - 1));
    assign install   = rdy && !flush && (state_q == ST_REFILL) && bus.mem_rd_valid && last_beat;

    // The pending line's tag and index live in the upper bits of mem_rd_addr_q.
    icache_array #(
        .DEPTH (CACHE_SZ),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .we       (install),
        .wr_idx   (mem_rd_addr_q[OFF_W +: IDX_W]),
        .wr_tag   (mem_rd_addr_q[ADDR_W-1 -: TAG_W]),
        .wr_data  (fill_line),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_comb begin
        fill_line         = line_q;
        fill_line[beat_q] = bus.mem_rd_data;
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        line_d        = line_q;
        resp_valid_d  = resp_valid_q;
        resp_inst_d   = resp_inst_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_rd_addr_d = mem_rd_addr_q;

        if (rdy) begin
            resp_valid_d = 1'b0;
            if (flush) begin
                state_d     = ST_IDLE;
                beat_d      = '0;
                mem_rd_en_d = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (hit) begin
                                resp_valid_d = 1'b1;
                                resp_inst_d  = rd_data;
                            end else begin
                                state_d       = ST_REFILL;
                                beat_d        = '0;
                                mem_rd_en_d   = 1'b1;
                                mem_rd_addr_d = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            end
                        end
                    end
                    ST_REFILL: begin
                        if (bus.mem_rd_valid) begin
                            line_d = fill_line;
                            beat_d = beat_q + OFF_W'(1);
                            if (last_beat) begin
                                state_d      = ST_RESP;
                                mem_rd_en_d  = 1'b0;
                                resp_valid_d = 1'b1;
                                resp_inst_d  = fill_line;
                            end else begin
                                mem_rd_addr_d = {mem_rd_addr_q[ADDR_W-1:OFF_W], beat_q + OFF_W'(1)};
                            end
                        end
                    end
                    ST_RESP: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            line_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_inst_q   <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            line_q        <= line_d;
            resp_valid_q  <= resp_valid_d;
            resp_inst_q   <= resp_inst_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    // A flush arriving while the refill response is on the bus cancels it in the same cycle.
    assign bus.resp_valid  = resp_valid_q & ~(rdy & flush & (state_q == ST_RESP));
    assign bus.resp_inst   = resp_inst_q;
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_rd_addr = mem_rd_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept) begin
            if (hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected responses, a negedge monitor pops and compares.
// Counter checks are compiled in when ICACHE_STAT_EN is defined.
module tb_icache;
    import icache_pkg::*;

    typedef struct {
        word_tp inst;
        int     due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rdy   = 1'b1;
    logic flush = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    icache_if bus ();

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache #(
        .CACHE_SZ (256),
        .LINE_SZ  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response is due in the cycle after the one in which the triggering input is presented.
    task automatic expect_resp(input word_tp w);
        sb_q.push_back('{inst: w, due: cyc + 1});
    endtask

    task automatic send_req(input addr_tp a, input logic f);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        flush         = f;
        @(negedge clk);
        check("req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic feed(input addr_tp base, input word_tp w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = w[8*i +: 8];
            if (i == 3) expect_resp(w);
            @(negedge clk);
            check("mem_rd_en", bus.mem_rd_en, 1);
            check("mem_rd_addr", bus.mem_rd_addr, base + 32'(i));
            step();
        end
        bus.mem_rd_valid = 1'b0;
    endtask

    task automatic wait_resp();
        @(negedge clk);
        check("mem_rd_en_off", bus.mem_rd_en, 0);
        step();
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_ready"}, bus.req_ready, 1);
        check({name, "_mem_en"}, bus.mem_rd_en, 0);
        step();
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            check("resp_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("resp_inst", bus.resp_inst, mon_e.inst);
                check("resp_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            check("resp_on_time", 32'(cyc), 32'(sb_q[0].due));
            mon_e = sb_q.pop_front();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;

        #1 rst = 1'b0;
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_inst", bus.resp_inst, 32'h0);
        check("rst_mem_rd_en", bus.mem_rd_en, 0);
        check("rst_mem_rd_addr", bus.mem_rd_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Cold miss, then hit, then conflicting tag, then original address misses again.
        send_req(32'h0000_1000, 1'b0);
        feed(32'h0000_1000, 32'h0000_0513, 0, 4);
        wait_resp();

        expect_resp(32'h0000_0513);
        send_req(32'h0000_1000, 1'b0);
        check_idle("hit");

        send_req(32'h0000_1400, 1'b0);
        feed(32'h0000_1400, 32'h0010_0093, 0, 4);
        wait_resp();

        send_req(32'h0000_1000, 1'b0);
        feed(32'h0000_1000, 32'h0000_0513, 0, 4);
        wait_resp();

`ifdef ICACHE_STAT_EN
        @(negedge clk);
        check("hit_cnt", hit_cnt, 32'd1);
        check("miss_cnt", miss_cnt, 32'd3);
        step();
`endif

        // Flush after two beats, with a byte offered in the flush cycle.
        send_req(32'h0000_2000, 1'b0);
        feed(32'h0000_2000, 32'h0000_0137, 0, 2);
        flush            = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 8'h00;
        step();
        flush            = 1'b0;
        bus.mem_rd_valid = 1'b0;
        check_idle("flush_refill");
        step();
        send_req(32'h0000_2000, 1'b0);
        feed(32'h0000_2000, 32'h0000_0137, 0, 4);
        wait_resp();

        // rdy low for three cycles mid-refill while garbage bytes arrive.
        send_req(32'h0000_2004, 1'b0);
        feed(32'h0000_2004, 32'h00a0_0093, 0, 2);
        rdy              = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 8'hff;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_mem_rd_addr", bus.mem_rd_addr, 32'h0000_2006);
            check("hold_mem_rd_en", bus.mem_rd_en, 1);
            step();
        end
        rdy              = 1'b1;
        bus.mem_rd_valid = 1'b0;
        feed(32'h0000_2004, 32'h00a0_0093, 2, 4);
        wait_resp();

        expect_resp(32'h00a0_0093);
        send_req(32'h0000_2004, 1'b0);
        check_idle("hit_after_hold");

        // Flush coincident with a hit and with a miss: both dropped.
        send_req(32'h0000_2004, 1'b1);
        check_idle("flush_hit");
        send_req(32'h0000_5000, 1'b1);
        check_idle("flush_miss");

        // Flush on the fourth byte: nothing installed, next access misses.
        send_req(32'h0000_3000, 1'b0);
        feed(32'h0000_3000, 32'h1122_3344, 0, 3);
        flush            = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 8'h11;
        step();
        flush            = 1'b0;
        bus.mem_rd_valid = 1'b0;
        check_idle("flush_last_beat");
        send_req(32'h0000_3000, 1'b0);
        feed(32'h0000_3000, 32'h1122_3344, 0, 4);
        wait_resp();

        // Asynchronous reset mid-refill clears outputs and valid bits.
        send_req(32'h0000_4000, 1'b0);
        feed(32'h0000_4000, 32'h5566_7788, 0, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_rd_en", bus.mem_rd_en, 0);
        check("arst_mem_rd_addr", bus.mem_rd_addr, 32'h0);
        check("arst_req_ready", bus.req_ready, 1);
        step();
        rst = 1'b1;
        step();
        send_req(32'h0000_2004, 1'b0);
        feed(32'h0000_2004, 32'h00a0_0093, 0, 4);
        wait_resp();

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
